// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - program counter and IF/ID register feeding decode
//
// Ports:
//   CLK, Reset            clock, synchronous active-high reset
//   Iaddr, IRW            byte address and read select to the instruction ROM
//   IData                 word returned by the ROM for Iaddr (same cycle)
//   id_valid/id_ready     IF/ID handshake towards decode
//   id_instr/id_pc/id_pc4 IF/ID contents
//   PCSrc, imm16, imm26,
//   jr_target             redirect request and operands from decode
//   halt_req              stop fetching after the current instruction is taken
//   halted, fault         terminal FSM states, cleared only by Reset
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_BYTES = 100
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [31:0] Iaddr,
    output logic        IRW,
    input  logic [31:0] IData,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] jr_target,
    input  logic        halt_req,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc4_q, ipc4_d;

    logic        load;
    logic        past_end;
    logic [31:0] target;

    assign Iaddr    = pc;
    assign IRW      = 1'b0;
    assign id_valid = valid_q;
    assign id_instr = instr_q;
    assign id_pc    = ipc_q;
    assign id_pc4   = ipc4_q;
    assign halted   = (state == S_HALT);
    assign fault    = (state == S_FAULT);

    assign load = !valid_q || id_ready;

    // 33-bit compare so a PC near 2^32 cannot wrap into the legal range.
    assign past_end = ({1'b0, pc} + 33'd3) >= 33'(ROM_BYTES);

    always_comb begin
        target = jr_target;
        case (PCSrc)
            2'b01:   target = ipc4_q + {{14{imm16[15]}}, imm16, 2'b00};
            2'b10:   target = {ipc4_q[31:28], imm26, 2'b00};
            2'b11:   target = jr_target;
            default: target = ipc4_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= S_RUN;
            pc      <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            ipc_q   <= 32'd0;
            ipc4_q  <= 32'd0;
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ipc4_d  = ipc4_q;
        case (state)
            S_RUN: begin
                if (valid_q && PCSrc != 2'b00) begin
                    // Redirect flushes the slot regardless of id_ready;
                    // a misaligned target faults and leaves PC alone.
                    valid_d = 1'b0;
                    if (target[1:0] != 2'b00) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d = target;
                    end
                end else if (valid_q && id_ready && halt_req) begin
                    valid_d = 1'b0;
                    state_d = S_HALT;
                end else if (load && (pc[1:0] != 2'b00 || past_end)) begin
                    valid_d = 1'b0;
                    state_d = S_FAULT;
                end else if (load) begin
                    instr_d = IData;
                    ipc_d   = pc;
                    ipc4_d  = pc + 32'd4;
                    valid_d = 1'b1;
                    pc_d    = pc + 32'd4;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - self-checking bench for pc_fetch_stage
module tb_pc_fetch_stage;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] Iaddr;
    logic        IRW;
    logic [31:0] IData;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [1:0]  PCSrc;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] jr_target;
    logic        halt_req;
    logic        halted;
    logic        fault;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    pc_fetch_stage #(.RESET_PC(32'h0000_0000), .ROM_BYTES(100)) dut (
        .CLK(CLK), .Reset(Reset), .Iaddr(Iaddr), .IRW(IRW), .IData(IData),
        .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc4(id_pc4), .PCSrc(PCSrc), .imm16(imm16),
        .imm26(imm26), .jr_target(jr_target), .halt_req(halt_req),
        .halted(halted), .fault(fault)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    // Instruction ROM model: word at byte address Iaddr, garbage past the end.
    always_comb IData = (Iaddr < 32'd100) ? rom_word(Iaddr) : 32'hBAD0_BAD0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; id_ready = 1'b0; PCSrc = 2'b00; halt_req = 1'b0;
        imm16 = 16'd0; imm26 = 26'd0; jr_target = 32'd0;
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({Iaddr, id_valid, id_instr, id_pc, id_pc4, halted, fault, IRW} !== {32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_state got Iaddr=%h v=%b instr=%h pc=%h pc4=%h h=%b f=%b irw=%b exp all zero",
                     Iaddr, id_valid, id_instr, id_pc, id_pc4, halted, fault, IRW);
        end
    endtask

    task automatic test_sequential();
        id_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({rom_word(32'(4 * k)), 32'(4 * k)});
            step();
            e = exp_q.pop_front();
            checks++;
            if ({id_valid, id_instr, id_pc, id_pc4, Iaddr} !== {1'b1, e.instr, e.pc, e.pc + 32'd4, 32'(4 * (k + 1))}) begin
                errors++;
                $display("FAIL seq_fetch%0d got v=%b instr=%h pc=%h pc4=%h Iaddr=%h exp instr=%h pc=%h Iaddr=%h",
                         k, id_valid, id_instr, id_pc, id_pc4, Iaddr, e.instr, e.pc, 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({id_valid, id_instr, id_pc, Iaddr} !== {1'b1, rom_word(32'd4), 32'd4, 32'd8}) begin
                errors++;
                $display("FAIL stall%0d got v=%b instr=%h pc=%h Iaddr=%h exp v=1 instr=%h pc=4 Iaddr=8",
                         k, id_valid, id_instr, id_pc, Iaddr, rom_word(32'd4));
            end
        end
        id_ready = 1'b1;
        exp_q.push_back({rom_word(32'd8), 32'd8});
        step();
        e = exp_q.pop_front();
        checks++;
        if ({id_valid, id_instr, id_pc, Iaddr} !== {1'b1, e.instr, e.pc, 32'd12}) begin
            errors++;
            $display("FAIL stall_release got v=%b instr=%h pc=%h Iaddr=%h exp instr=%h pc=%h Iaddr=c",
                     id_valid, id_instr, id_pc, Iaddr, e.instr, e.pc);
        end
    endtask

    task automatic test_branch();
        do_reset();
        id_ready = 1'b1;
        step();
        step();
        checks++;
        if ({id_valid, id_pc4, Iaddr} !== {1'b1, 32'd8, 32'd8}) begin
            errors++;
            $display("FAIL branch_setup got v=%b pc4=%h Iaddr=%h exp v=1 pc4=8 Iaddr=8", id_valid, id_pc4, Iaddr);
        end
        id_ready = 1'b0; PCSrc = 2'b01; imm16 = 16'hFFFE;
        step();
        checks++;
        if ({Iaddr, id_valid, fault} !== {32'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL branch_redirect got Iaddr=%h v=%b f=%b exp Iaddr=0 v=0 f=0", Iaddr, id_valid, fault);
        end
        PCSrc = 2'b00; id_ready = 1'b1;
        exp_q.push_back({rom_word(32'd0), 32'd0});
        step();
        e = exp_q.pop_front();
        checks++;
        if ({id_valid, id_instr, id_pc} !== {1'b1, e.instr, e.pc}) begin
            errors++;
            $display("FAIL branch_target_fetch got v=%b instr=%h pc=%h exp instr=%h pc=%h",
                     id_valid, id_instr, id_pc, e.instr, e.pc);
        end
    endtask

    task automatic test_jump();
        PCSrc = 2'b10; imm26 = 26'h5;
        step();
        checks++;
        if ({Iaddr, id_valid, fault} !== {32'd20, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL jump_redirect got Iaddr=%h v=%b f=%b exp Iaddr=14 v=0 f=0", Iaddr, id_valid, fault);
        end
        PCSrc = 2'b00;
        exp_q.push_back({rom_word(32'd20), 32'd20});
        step();
        e = exp_q.pop_front();
        checks++;
        if ({id_valid, id_instr, id_pc, Iaddr} !== {1'b1, e.instr, e.pc, 32'd24}) begin
            errors++;
            $display("FAIL jump_target_fetch got v=%b instr=%h pc=%h Iaddr=%h exp instr=%h pc=%h Iaddr=18",
                     id_valid, id_instr, id_pc, Iaddr, e.instr, e.pc);
        end
        PCSrc = 2'b11; jr_target = 32'h0000_0006;
        step();
        PCSrc = 2'b00;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({fault, halted, id_valid, Iaddr} !== {1'b1, 1'b0, 1'b0, 32'd24}) begin
                errors++;
                $display("FAIL jr_misaligned%0d got f=%b h=%b v=%b Iaddr=%h exp f=1 h=0 v=0 Iaddr=18",
                         k, fault, halted, id_valid, Iaddr);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        id_ready = 1'b1;
        for (int k = 0; k < 25; k++) begin
            exp_q.push_back({rom_word(32'(4 * k)), 32'(4 * k)});
            step();
            e = exp_q.pop_front();
            checks++;
            if ({id_valid, id_instr, id_pc, Iaddr, fault} !== {1'b1, e.instr, e.pc, e.pc + 32'd4, 1'b0}) begin
                errors++;
                $display("FAIL b2b_fetch%0d got v=%b instr=%h pc=%h Iaddr=%h f=%b exp instr=%h pc=%h",
                         k, id_valid, id_instr, id_pc, Iaddr, fault, e.instr, e.pc);
            end
        end
        step();
        checks++;
        if ({fault, id_valid, Iaddr} !== {1'b1, 1'b0, 32'd100}) begin
            errors++;
            $display("FAIL rom_end_fault got f=%b v=%b Iaddr=%h exp f=1 v=0 Iaddr=64", fault, id_valid, Iaddr);
        end
    endtask

    task automatic test_halt();
        do_reset();
        id_ready = 1'b1;
        step();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({halted, fault, id_valid, Iaddr} !== {1'b1, 1'b0, 1'b0, 32'd4}) begin
                errors++;
                $display("FAIL halt%0d got h=%b f=%b v=%b Iaddr=%h exp h=1 f=0 v=0 Iaddr=4",
                         k, halted, fault, id_valid, Iaddr);
            end
            step();
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        checks++;
        if ({halted, fault, Iaddr} !== {1'b0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_from_halt got h=%b f=%b Iaddr=%h exp 0 0 0", halted, fault, Iaddr);
        end
        id_ready = 1'b1;
        step();
        step();
        id_ready = 1'b0; Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if ({Iaddr, id_valid, halted, fault} !== {32'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in_stall got Iaddr=%h v=%b h=%b f=%b exp 0 0 0 0", Iaddr, id_valid, halted, fault);
        end
        id_ready = 1'b1;
        step();
        PCSrc = 2'b10; imm26 = 26'h5; Reset = 1'b1;
        step();
        Reset = 1'b0; PCSrc = 2'b00;
        checks++;
        if ({Iaddr, id_valid, halted, fault} !== {32'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in_redirect got Iaddr=%h v=%b h=%b f=%b exp 0 0 0 0", Iaddr, id_valid, halted, fault);
        end
        exp_q.push_back({rom_word(32'd0), 32'd0});
        step();
        e = exp_q.pop_front();
        checks++;
        if ({id_valid, id_instr, id_pc, Iaddr} !== {1'b1, e.instr, e.pc, 32'd4}) begin
            errors++;
            $display("FAIL restart_after_reset got v=%b instr=%h pc=%h Iaddr=%h exp instr=%h pc=%h Iaddr=4",
                     id_valid, id_instr, id_pc, Iaddr, e.instr, e.pc);
        end
    endtask

    initial begin
        Reset = 1'b1; id_ready = 1'b0; PCSrc = 2'b00; halt_req = 1'b0;
        imm16 = 16'd0; imm26 = 26'd0; jr_target = 32'd0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump();
        test_back_to_back();
        test_halt();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
